// File: rtl/interrupt_request_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_request_controller_if
// Brief    : Request/enable/claim bundle between CPU side and IRQ controller.
// Revision : 1.0 - initial release
// ============================================================================
interface interrupt_request_controller_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
);
    logic [NUM_SRC-1:0] src_req;
    logic               en_wr;
    logic [NUM_SRC-1:0] en_data;
    logic               irq_ack;
    logic               irq_eoi;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;

    modport master (
        output src_req, en_wr, en_data, irq_ack, irq_eoi,
        input  irq, irq_id, pending, enable
    );

    modport slave (
        input  src_req, en_wr, en_data, irq_ack, irq_eoi,
        output irq, irq_id, pending, enable
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_request_controller
// Brief    : Edge-latched, fixed-priority interrupt controller with ACK/EOI
//            handshake and a guaranteed IRQ low gap between requests.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_request_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3,
    parameter int GAP_CYC = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    interrupt_request_controller_if.slave irq_bus
);

    localparam logic [3:0] c_gap_load = 4'(GAP_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_armed;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_selectable;
    logic [NUM_SRC-1:0] w_clr_mask;
    logic [NUM_SRC-1:0] w_pending_nxt;

    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_irq_id_nxt;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_sel_valid;

    logic               r_irq;
    logic               w_irq_nxt;
    logic [3:0]         r_gap_cnt;
    logic [3:0]         w_gap_nxt;
    logic               w_ack_take;

    // A source must be seen low after reset before its edges count, so a
    // line held high through reset cannot fake a rising edge.
    assign w_rise       = irq_bus.src_req & ~r_src_q & r_armed;
    assign w_selectable = r_pending & r_enable;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_selectable[i]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_nxt    = r_irq;
        w_irq_id_nxt = r_irq_id;
        w_gap_nxt    = r_gap_cnt;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt  = ST_REQ;
                    w_irq_nxt    = 1'b1;
                    w_irq_id_nxt = w_sel_id;
                end
            end
            ST_REQ: begin
                // ACK has precedence; a coincident EOI is dropped.
                if (irq_bus.irq_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_ack_take  = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (irq_bus.irq_eoi) begin
                    w_state_nxt = ST_GAP;
                    w_irq_nxt   = 1'b0;
                    w_gap_nxt   = c_gap_load;
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap_cnt - 4'd1;
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_gap_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_clr_mask = '0;
        if (w_ack_take) begin
            w_clr_mask[r_irq_id] = 1'b1;
        end
    end

    // Set after clear: a fresh edge on the claimed source stays pending.
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_src_q   <= '0;
            r_armed   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
            r_gap_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_src_q   <= irq_bus.src_req;
            r_armed   <= r_armed | ~irq_bus.src_req;
            r_pending <= w_pending_nxt;
            if (irq_bus.en_wr) begin
                r_enable <= irq_bus.en_data;
            end
            r_irq     <= w_irq_nxt;
            r_irq_id  <= w_irq_id_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    assign irq_bus.irq     = r_irq;
    assign irq_bus.irq_id  = r_irq_id;
    assign irq_bus.pending = r_pending;
    assign irq_bus.enable  = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_request_controller
// Brief    : Directed scoreboard bench for interrupt_request_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_request_controller;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;
    localparam int GAP_CYC = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        int              low_len;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    interrupt_request_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

    interrupt_request_controller #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en(input logic [NUM_SRC-1:0] m);
        bus.en_data = m;
        bus.en_wr   = 1'b1;
        tick();
        bus.en_wr   = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_eoi = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int k = 0;
        while (!bus.irq && k < 50) begin
            tick();
            k++;
        end
        n_total++;
        if (bus.irq) n_pass++;
        else $display("FAIL %s: irq got 0 expected 1 within 50 cycles", name);
    endtask

    task automatic serve(input string name);
        wait_irq(name);
        tick();
        ack_pulse();
        tick();
        eoi_pulse();
    endtask

    task automatic settle();
        repeat (GAP_CYC + 3) tick();
    endtask

    // Monitor: every IRQ rising edge pops one expected request.
    initial begin : monitor
        logic prev;
        int   low;
        exp_t e;
        prev = 1'b0;
        low  = 0;
        forever begin
            @(negedge clk);
            if (bus.irq && !prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_irq: got id %0d expected no request", bus.irq_id);
                end else begin
                    e = exp_q.pop_front();
                    check("irq_id", 32'(bus.irq_id), 32'(e.id));
                    if (e.low_len > 0) check("irq_low_gap", 32'(low), 32'(e.low_len));
                end
            end
            low  = bus.irq ? 0 : low + 1;
            prev = bus.irq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.src_req = '0;
        bus.en_wr   = 1'b0;
        bus.en_data = '0;
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_irq_id", 32'(bus.irq_id), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_enable", 32'(bus.enable), 0);

        // Single source, exact timing.
        pulse_en(8'hFF);
        check("en_ff", 32'(bus.enable), 32'hFF);
        exp_q.push_back('{id: 3'd5, low_len: 0});
        bus.src_req[5] = 1'b1;
        tick();
        check("t1_pending_set", 32'(bus.pending), 32'h20);
        check("t1_irq_not_yet", 32'(bus.irq), 0);
        tick();
        check("t1_irq_up", 32'(bus.irq), 1);
        check("t1_id", 32'(bus.irq_id), 5);
        tick(); tick();
        ack_pulse();
        check("t1_pending_clr", 32'(bus.pending), 0);
        check("t1_irq_service", 32'(bus.irq), 1);
        tick(); tick();
        eoi_pulse();
        check("t1_gap0", 32'(bus.irq), 0);
        tick();
        check("t1_gap1", 32'(bus.irq), 0);
        tick();
        check("t1_idle", 32'(bus.irq), 0);
        check("t1_id_hold", 32'(bus.irq_id), 5);
        bus.src_req = '0;
        tick();

        // Two simultaneous sources: priority then fresh edge after gap.
        exp_q.push_back('{id: 3'd2, low_len: 0});
        exp_q.push_back('{id: 3'd6, low_len: GAP_CYC + 1});
        bus.src_req = 8'h44;
        tick();
        check("t2_pending_both", 32'(bus.pending), 32'h44);
        serve("t2_first");
        serve("t2_second");
        settle();
        check("t2_pending_empty", 32'(bus.pending), 0);
        bus.src_req = '0;
        tick();

        // Disabled source latches but is not selected until enabled.
        pulse_en(8'h00);
        bus.src_req[3] = 1'b1;
        tick();
        check("t3_pending", 32'(bus.pending), 32'h08);
        tick(); tick();
        check("t3_masked", 32'(bus.irq), 0);
        exp_q.push_back('{id: 3'd3, low_len: 0});
        pulse_en(8'h08);
        check("t3_not_before_en", 32'(bus.irq), 0);
        tick();
        check("t3_irq_after_en", 32'(bus.irq), 1);
        check("t3_id", 32'(bus.irq_id), 3);
        serve("t3");
        settle();
        bus.src_req = '0;
        tick();

        // Re-edge on the claimed source in the ACK cycle stays pending.
        pulse_en(8'hFF);
        exp_q.push_back('{id: 3'd1, low_len: 0});
        exp_q.push_back('{id: 3'd1, low_len: GAP_CYC + 1});
        bus.src_req[1] = 1'b1;
        wait_irq("t4_first");
        bus.src_req[1] = 1'b0;
        tick();
        bus.src_req[1] = 1'b1;
        bus.irq_ack    = 1'b1;
        tick();
        bus.irq_ack    = 1'b0;
        check("t4_set_wins", 32'(bus.pending), 32'h02);
        tick();
        eoi_pulse();
        check("t4_gap", 32'(bus.irq), 0);
        serve("t4_second");
        settle();
        check("t4_pending_empty", 32'(bus.pending), 0);
        bus.src_req = '0;
        tick();

        // Reset during SERVICE, stray pulses, source held through reset.
        exp_q.push_back('{id: 3'd4, low_len: 0});
        bus.src_req[4] = 1'b1;
        bus.src_req[0] = 1'b0;
        wait_irq("t5_first");
        tick();
        ack_pulse();
        check("t5_service", 32'(bus.irq), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_irq", 32'(bus.irq), 0);
        check("t5_rst_pending", 32'(bus.pending), 0);
        check("t5_rst_enable", 32'(bus.enable), 0);
        eoi_pulse();
        ack_pulse();
        check("t5_stray_irq", 32'(bus.irq), 0);
        pulse_en(8'hFF);
        tick(); tick();
        check("t5_held_no_pend", 32'(bus.pending), 0);
        check("t5_held_no_irq", 32'(bus.irq), 0);
        bus.src_req[4] = 1'b0;
        tick();
        exp_q.push_back('{id: 3'd4, low_len: 0});
        bus.src_req[4] = 1'b1;
        tick();
        check("t5_new_edge", 32'(bus.pending), 32'h10);
        wait_irq("t5_second");
        bus.irq_ack = 1'b1;
        bus.irq_eoi = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;
        check("t5_ack_only", 32'(bus.irq), 1);
        check("t5_ack_cleared", 32'(bus.pending), 0);
        eoi_pulse();
        check("t5_eoi", 32'(bus.irq), 0);
        settle();
        bus.src_req = '0;
        tick();

        check("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_request_controller.md
INTERRUPT_REQUEST_CONTROLLER -- requirements
Module: interrupt_request_controller

Interface
REQ-001 Parameter NUM_SRC, default 8, SHALL set the number of interrupt sources; it SHALL be a power of two, 2..16.
REQ-002 Parameter ID_W, default 3, SHALL set the IRQ_ID width and SHALL equal log2(NUM_SRC).
REQ-003 Parameter GAP_CYC, default 2, SHALL set the minimum number of cycles IRQ stays low between two requests; range 1..15.
REQ-004 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 SRC_REQ  input  NUM_SRC  SHALL carry per-source request levels; a request is a 0->1 transition.
REQ-007 EN_WR  input  1  SHALL load EN_DATA into the enable register when high.
REQ-008 EN_DATA  input  NUM_SRC  SHALL be the new enable mask; bit=1 enables that source.
REQ-009 IRQ_ACK  input  1  SHALL be the one-cycle CPU claim pulse: the CPU has saved PC and branched to the ISR.
REQ-010 IRQ_EOI  input  1  SHALL be the one-cycle end-of-ISR pulse from the CPU.
REQ-011 IRQ  output  1  SHALL be the registered interrupt request to the CPU.
REQ-012 IRQ_ID  output  ID_W  SHALL give the index of the source being requested or serviced.
REQ-013 PENDING  output  NUM_SRC  SHALL show the pending register.
REQ-014 ENABLE  output  NUM_SRC  SHALL show the enable register.

Function
REQ-015 Edge detection SHALL register SRC_REQ each cycle; a bit whose registered value is 0 and whose current value is 1 SHALL set PENDING[i] at that edge.
REQ-016 A source SHALL latch into PENDING whatever its ENABLE bit; ENABLE SHALL gate only selection.
REQ-017 Selection SHALL take the lowest index i with PENDING[i] & ENABLE[i] = 1 (index 0 has highest priority).
REQ-018 The FSM SHALL have states IDLE, REQ, SERVICE and GAP.
REQ-019 In IDLE with a selectable source, the FSM SHALL move to REQ at the next edge, latch the selected index into IRQ_ID and set IRQ=1, so IRQ rises one cycle after PENDING is set.
REQ-020 In REQ, IRQ SHALL stay 1 and IRQ_ID SHALL stay stable; on IRQ_ACK the FSM SHALL clear PENDING[IRQ_ID] and move to SERVICE.
REQ-021 In SERVICE, IRQ SHALL stay 1; on IRQ_EOI the FSM SHALL set IRQ=0, load the gap counter with GAP_CYC and move to GAP.
REQ-022 In GAP, the counter SHALL decrement each cycle; at 0 the FSM SHALL return to IDLE, so IRQ is low for at least GAP_CYC cycles and every new request gives a fresh IRQ rising edge.
REQ-023 IRQ_ACK outside REQ and IRQ_EOI outside SERVICE SHALL be ignored; a simultaneous ACK and EOI in REQ SHALL be treated as ACK only.
REQ-024 If a source edge and an ACK clear target the same PENDING bit in one cycle, the set SHALL win, and the bit SHALL stay pending.
REQ-025 Once REQ is entered the request SHALL be committed: clearing its ENABLE bit afterwards SHALL NOT withdraw IRQ or change IRQ_ID.
REQ-026 An EN_WR SHALL take effect at the next edge and SHALL be visible to selection from that cycle on.
REQ-027 In IDLE and GAP, IRQ_ID SHALL hold its last value.
REQ-028 New edges during REQ, SERVICE or GAP SHALL only set PENDING; they SHALL be served in priority order after GAP.

Reset
REQ-029 With RESET high at an edge: state SHALL become IDLE; IRQ, IRQ_ID, PENDING, ENABLE, the gap counter and the SRC_REQ history register SHALL become 0.
REQ-030 A RESET mid-request SHALL drop IRQ on the next edge and SHALL discard all pending requests.
REQ-031 A source held high through reset SHALL NOT produce a request until it goes low and high again.

Verification
REQ-032 EN=0xFF; SRC_REQ[5] rises at cycle 10 -> PENDING=0x20 at 11, IRQ=1 and IRQ_ID=5 at 12; ACK at 14 -> PENDING=0x00; EOI at 17 -> IRQ=0 for 2 cycles, then IDLE.
REQ-033 EN=0xFF; SRC_REQ[6] and SRC_REQ[2] rise together -> IRQ_ID=2 first; after EOI and gap, a new IRQ rising edge with IRQ_ID=6.
REQ-034 EN=0x00; SRC_REQ[3] rises -> PENDING=0x08 and IRQ stays 0; write EN=0x08 -> IRQ=1 and IRQ_ID=3 one cycle later.
REQ-035 While in REQ with IRQ_ID=1, SRC_REQ[1] re-rises in the ACK cycle -> PENDING[1] stays 1, and a second IRQ for ID 1 follows the gap.
REQ-036 Assert RESET during SERVICE, then release -> IRQ=0, PENDING=0, ENABLE=0; stray EOI and ACK pulses SHALL be ignored.
